shared_mul_arbiter: RTL and testbench
=====================================

SHARED_MUL_ARBITER -- requirements
Module: shared_mul_arbiter

Interface
REQ-001 Parameter: n, default 8, operand width in bits.
REQ-002 Ports: clk  input  1  rising-edge clock.
REQ-003 Ports: rst  input  1  reset, synchronous, active-high.
REQ-004 Ports: req0_valid / req1_valid  input  1 each  request present.
REQ-005 Ports: req0_ready / req1_ready  output  1 each  request accepted this cycle.
REQ-006 Ports: req0_a, req0_b / req1_a, req1_b  input  n each  operands.
REQ-007 Ports: req0_signed / req1_signed  input  1 each  1 = two's-complement multiply, 0 = unsigned multiply.
REQ-008 Ports: res_valid  output  1  result present; no backpressure.
REQ-009 Ports: res_id  output  1  index of the requester that owns the result.
REQ-010 Ports: res  output  2n  product.

Function
REQ-011 A request SHALL be accepted in a cycle where reqX_valid and reqX_ready are both 1.
REQ-012 At most one of req0_ready and req1_ready SHALL be 1 in any cycle.
REQ-013 reqX_ready SHALL be combinational from the valids and the arbiter state; it SHALL be 0 while reqX_valid is 0 and while rst is 1.
REQ-014 If only one requester is valid, that requester SHALL be granted in the same cycle.
REQ-015 If both are valid, the requester not granted most recently SHALL be granted (round-robin); last_grant updates only on acceptance.
REQ-016 The multiplier SHALL be a 2-stage pipeline: operands and mode registered on acceptance, product registered in the next cycle.
REQ-017 res_valid, res_id and res SHALL appear exactly 2 cycles after the accepting edge, with throughput of one accepted request per cycle.
REQ-018 Signed mode SHALL produce the exact 2n-bit two's-complement product; unsigned mode SHALL produce the exact 2n-bit zero-extended product; there SHALL be no truncation or overflow.
REQ-019 res and res_id SHALL hold their last values while res_valid is 0; checkers SHALL ignore them in that state.
REQ-020 Mode and id SHALL travel with the operands; results SHALL leave in acceptance order, with no reordering or loss.
REQ-021 A requester held valid with stable operands SHALL be granted within 2 cycles when the other requester is also continuously valid (no starvation).

Reset
REQ-022 On a clk edge with rst=1: res_valid SHALL become 0, both pipeline valid bits SHALL clear, res SHALL become 0, res_id SHALL become 0, and last_grant SHALL become 1, so req0 wins the first tie.
REQ-023 Reset asserted mid-operation SHALL discard all in-flight products; no res_valid pulse SHALL occur for requests accepted before reset.

Configuration
REQ-024 Macro SHARED_MUL_ARBITER_ROUND_ROBIN_EN defined: arbitration SHALL follow REQ-015.
REQ-025 Macro undefined: arbitration SHALL be fixed-priority, with req0 always winning ties; REQ-021 SHALL not apply and the last_grant register SHALL not exist.

Structure
REQ-026 Package shared_mul_pkg SHALL hold the constant MUL_LATENCY = 2, the typedef req_id_t (1 bit), and a packed struct typedef for a pipeline entry (valid, id, signed_mul, operands).
REQ-027 The pipelined datapath SHALL be a sub-module, mul_pipe_2, parameterized by n, with inputs in_valid, in_signed, in_id, a, b and outputs out_valid, out_id, res; arbitration logic SHALL stay in the top module.

Verification (n=4)
REQ-028 Only req0 valid, signed, a=4'b1000, b=4'b1000 -> req0_ready=1 same cycle; 2 cycles later res_valid=1, res_id=0, res=8'h40.
REQ-029 Only req1 valid, unsigned, a=4'hF, b=4'hF -> 2 cycles later res_id=1, res=8'hE1; same operands signed -> res=8'h01.
REQ-030 Both valid every cycle for 6 cycles after reset (req0 signed -1*7, req1 unsigned 3*5) -> grants alternate 0,1,0,1,0,1; results alternate 8'hF9, 8'h0F at 1 per cycle.
REQ-031 Same stimulus as REQ-030 with the macro undefined -> req0 granted every cycle; req1_ready stays 0.
REQ-032 Accept two back-to-back requests, then assert rst for 1 cycle on the edge after the second acceptance -> no res_valid in the following 3 cycles; the next request after reset is granted to req0 on a tie.
REQ-033 Exhaustive sweep: all 256 operand pairs in each mode via alternating requesters -> every res matches the golden signed or unsigned product, tagged with the correct res_id.

Source files
------------

// File: rtl/shared_mul_arbiter_pkg.sv
// Shared types and constants for the two-requester shared multiplier.
// Build option: SHARED_MUL_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration.
package shared_mul_pkg;

  // Cycles from the accepting cycle to the cycle the result is presented.
  localparam int unsigned MUL_LATENCY = 2;

  // Widest operand a pipeline entry can carry; instances must use n <= OP_W_MAX.
  localparam int unsigned OP_W_MAX = 32;

  typedef logic req_id_t;

  // One multiplier pipeline slot: control plus raw (zero-extended) operands.
  typedef struct packed {
    logic                valid;
    req_id_t             id;
    logic                signed_mul;
    logic [OP_W_MAX-1:0] a;
    logic [OP_W_MAX-1:0] b;
  } pipe_entry_t;

endpackage

// File: rtl/shared_mul_arbiter_mul_pipe_2.sv
// Two-stage multiplier: operands/mode/id captured in stage 1, product in stage 2.
// Operands are stored raw; sign or zero extension happens in stage 2 from the mode bit.
module mul_pipe_2
  import shared_mul_pkg::*;
#(
  parameter int unsigned n = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic           in_signed,
  input  req_id_t        in_id,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           out_valid,
  output req_id_t        out_id,
  output logic [2*n-1:0] res
);

  localparam int unsigned RES_W = 2 * n;
  localparam int unsigned SH    = OP_W_MAX - n;

  pipe_entry_t              s1_q, s1_d;
  logic                     out_valid_q;
  req_id_t                  out_id_q;
  logic [RES_W-1:0]         res_q;

  logic [OP_W_MAX-1:0]        a_al, b_al;
  logic signed [OP_W_MAX-1:0] a_sx, b_sx;
  logic [RES_W-1:0]           a_ext, b_ext, prod_c;

  // Stage-1 load: capture a new entry on acceptance, otherwise keep operands and drop valid.
  always_comb begin
    s1_d       = s1_q;
    s1_d.valid = in_valid;
    if (in_valid) begin
      s1_d.id         = in_id;
      s1_d.signed_mul = in_signed;
      s1_d.a          = OP_W_MAX'(a);
      s1_d.b          = OP_W_MAX'(b);
    end
  end

  // Stage-2 math: extend both operands to 2n bits; the low 2n bits of the product are exact.
  always_comb begin
    a_al   = s1_q.a << SH;
    b_al   = s1_q.b << SH;
    a_sx   = $signed(a_al) >>> SH;
    b_sx   = $signed(b_al) >>> SH;
    a_ext  = s1_q.signed_mul ? RES_W'(a_sx) : RES_W'(s1_q.a);
    b_ext  = s1_q.signed_mul ? RES_W'(b_sx) : RES_W'(s1_q.b);
    prod_c = RES_W'(a_ext * b_ext);
  end

  // Pipeline registers; result fields only move when a valid entry arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      res_q       <= '0;
    end else begin
      s1_q        <= s1_d;
      out_valid_q <= s1_q.valid;
      if (s1_q.valid) begin
        out_id_q <= s1_q.id;
        res_q    <= prod_c;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign res       = res_q;

endmodule

// File: rtl/shared_mul_arbiter.sv
// Two requesters sharing one pipelined multiplier.
// Build option: SHARED_MUL_ARBITER_ROUND_ROBIN_EN selects round-robin; otherwise req0 has fixed priority.
module shared_mul_arbiter
  import shared_mul_pkg::*;
#(
  parameter int unsigned n = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [n-1:0]   req0_a,
  input  logic [n-1:0]   req0_b,
  input  logic [n-1:0]   req1_a,
  input  logic [n-1:0]   req1_b,
  input  logic           req0_signed,
  input  logic           req1_signed,
  output logic           res_valid,
  output req_id_t        res_id,
  output logic [2*n-1:0] res
);

  logic         acc_valid;
  req_id_t      acc_id;
  logic         acc_signed;
  logic [n-1:0] acc_a, acc_b;

`ifdef SHARED_MUL_ARBITER_ROUND_ROBIN_EN
  req_id_t last_grant_q, last_grant_d;

  // Round-robin grant: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      req0_ready = req0_valid && (!req1_valid || (last_grant_q == 1'b1));
      req1_ready = req1_valid && (!req0_valid || (last_grant_q == 1'b0));
    end
  end

  // Remember the winner only when a request is actually accepted.
  always_comb begin
    last_grant_d = last_grant_q;
    if (req0_ready) begin
      last_grant_d = 1'b0;
    end else if (req1_ready) begin
      last_grant_d = 1'b1;
    end
  end

  // Reset to 1 so req0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority grant: req0 always wins a tie.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      req0_ready = req0_valid;
      req1_ready = req1_valid && !req0_valid;
    end
  end
`endif

  // Steer the granted request into the multiplier.
  always_comb begin
    acc_valid  = req0_ready || req1_ready;
    acc_id     = req1_ready ? 1'b1 : 1'b0;
    acc_signed = req1_ready ? req1_signed : req0_signed;
    acc_a      = req1_ready ? req1_a : req0_a;
    acc_b      = req1_ready ? req1_b : req0_b;
  end

  mul_pipe_2 #(
    .n (n)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (acc_valid),
    .in_signed (acc_signed),
    .in_id     (acc_id),
    .a         (acc_a),
    .b         (acc_b),
    .out_valid (res_valid),
    .out_id    (res_id),
    .res       (res)
  );

endmodule

// File: tb/tb_shared_mul_arbiter.sv
// Self-checking bench for shared_mul_arbiter at n=4: grant vectors plus a result scoreboard.
module tb_shared_mul_arbiter;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_signed, req1_signed;
  logic         res_valid;
  logic         res_id;
  logic [2*N-1:0] res;

  always #5 clk = ~clk;

  shared_mul_arbiter #(.n(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req1_valid  (req1_valid),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req0_signed (req0_signed),
    .req1_signed (req1_signed),
    .res_valid   (res_valid),
    .res_id      (res_id),
    .res         (res)
  );

  typedef struct packed {
    logic       id;
    logic [7:0] res;
  } exp_t;

  typedef struct {
    logic       v0, s0;
    logic [3:0] a0, b0;
    logic       v1, s1;
    logic [3:0] a1, b1;
    logic [1:0] g;     // expected {req1_ready, req0_ready}
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[10];
  int   total = 0;
  int   bad   = 0;
  int   res_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Golden product from integer arithmetic.
  function automatic logic [7:0] gold(input logic [3:0] a, input logic [3:0] b, input logic s);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (s) begin
      if (a[3]) ia = ia - 16;
      if (b[3]) ib = ib - 16;
    end
    return 8'(ia * ib);
  endfunction

  // Drive one cycle of requests, check grants, queue the expected result.
  task automatic step(input logic v0, input logic s0, input logic [3:0] a0, input logic [3:0] b0,
                      input logic v1, input logic s1, input logic [3:0] a1, input logic [3:0] b1,
                      input logic [1:0] g, input string name);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_signed = s0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_signed = s1; req1_a = a1; req1_b = b1;
    #1;
    check(name, 32'({req1_ready, req0_ready}), 32'(g));
    if (req0_valid && req0_ready) sbq.push_back({1'b0, gold(a0, b0, s0)});
    else if (req1_valid && req1_ready) sbq.push_back({1'b1, gold(a1, b1, s1)});
  endtask

  // Result monitor: every presented result must match the oldest expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (res_valid) begin
      res_cnt++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got id=%0d res=%0h want none", res_id, res);
      end else begin
        e = sbq.pop_front();
        check("res_id", 32'(res_id), 32'(e.id));
        check("res", 32'(res), 32'(e.res));
      end
    end
  end

  initial begin
    int cnt0;
    logic [7:0] iv;
    int k;

    // Vectors: six tied cycles straight after reset, then single-requester cases.
    for (int i = 0; i < 6; i++) begin
      tbl[i] = '{v0: 1'b1, s0: 1'b1, a0: 4'hF, b0: 4'h7,
                 v1: 1'b1, s1: 1'b0, a1: 4'h3, b1: 4'h5, g: 2'b01};
`ifdef SHARED_MUL_ARBITER_ROUND_ROBIN_EN
      if (i % 2 == 1) tbl[i].g = 2'b10;
`endif
    end
    tbl[6] = '{v0: 1'b1, s0: 1'b1, a0: 4'h8, b0: 4'h8, v1: 1'b0, s1: 1'b0, a1: 4'h0, b1: 4'h0, g: 2'b01};
    tbl[7] = '{v0: 1'b0, s0: 1'b0, a0: 4'h0, b0: 4'h0, v1: 1'b1, s1: 1'b0, a1: 4'hF, b1: 4'hF, g: 2'b10};
    tbl[8] = '{v0: 1'b0, s0: 1'b0, a0: 4'h0, b0: 4'h0, v1: 1'b1, s1: 1'b1, a1: 4'hF, b1: 4'hF, g: 2'b10};
    tbl[9] = '{v0: 1'b0, s0: 1'b1, a0: 4'h3, b0: 4'h3, v1: 1'b0, s1: 1'b1, a1: 4'h3, b1: 4'h3, g: 2'b00};

    // Reset with both requesters asserting: no grants allowed.
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_signed = 1'b0; req1_signed = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    #2;
    check("ready_in_reset", 32'({req1_ready, req0_ready}), 32'(2'b00));
    @(negedge clk);
    check("reset_res_valid", 32'(res_valid), 32'(0));
    check("reset_res", 32'(res), 32'(0));
    check("reset_res_id", 32'(res_id), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;

    foreach (tbl[i])
      step(tbl[i].v0, tbl[i].s0, tbl[i].a0, tbl[i].b0,
           tbl[i].v1, tbl[i].s1, tbl[i].a1, tbl[i].b1, tbl[i].g, $sformatf("vec%0d_grant", i));

    // Exhaustive sweep in both modes, alternating requesters.
    k = 0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) begin
        iv = 8'(i);
        if (k % 2 == 0)
          step(1'b1, s[0], iv[7:4], iv[3:0], 1'b0, 1'b0, 4'h0, 4'h0, 2'b01, "sweep_grant0");
        else
          step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, s[0], iv[7:4], iv[3:0], 2'b10, "sweep_grant1");
        k++;
      end
    end
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, "idle_grant");
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, "idle_grant");
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, "idle_grant");

    // Mid-operation reset: two back-to-back acceptances, reset sampled on the following edge.
    step(1'b1, 1'b1, 4'h2, 4'h3, 1'b0, 1'b0, 4'h0, 4'h0, 2'b01, "pre_rst_grant0");
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h5, 4'h5, 2'b10, "pre_rst_grant1");
    @(posedge clk);
    #1;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("ready_mid_reset", 32'({req1_ready, req0_ready}), 32'(2'b00));
    @(posedge clk);
    #1;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    sbq.delete();
    cnt0 = res_cnt;
    repeat (3) @(negedge clk);
    check("no_result_after_reset", 32'(res_cnt - cnt0), 32'(0));
    step(1'b1, 1'b0, 4'h6, 4'h7, 1'b1, 1'b0, 4'h1, 4'h1, 2'b01, "tie_after_reset");
    step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b00, "idle_grant");

    // Drain outstanding results within a bounded wait.
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sbq.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
